alu_resp_sig: RTL and testbench

Response-side collector for the 4-bit ALU stimulus stream. It samples each valid ALU result together with its opcode and compresses the stream into a signature register (MISR). It counts samples and, after a programmed number, compares the signature against a golden value and reports pass/fail. The block sits at the ALU output, opposite the random stimulus generator, so long random runs self-check with no waveform inspection.

---
 rtl/alu_resp_sig.sv | 128 ++++++++++++
 tb/tb_alu_resp_sig.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_sig.sv
// Response collector for the 4-bit ALU stream: folds each valid {op, ans}
// into a MISR signature and checks it against a golden value after a run.
module alu_resp_sig #(
    parameter int                 SIG_W       = 16,
    parameter logic [SIG_W-1:0]   POLY        = 16'h1021,
    parameter logic [SIG_W-1:0]   SEED        = 16'hFFFF,
    parameter int                 NUM_SAMPLES = 300,
    parameter int                 CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [3:0]       ans,
    input  logic [1:0]       op,
    input  logic [SIG_W-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             pass_q, pass_d;
    logic             busy_q, done_q;

    // One MISR step: shift left, fold POLY back in when the MSB falls out, then mix the sample.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                   input logic [1:0]       op_v,
                                                   input logic [3:0]       ans_v);
        logic [SIG_W-1:0] shifted;
        logic [SIG_W-1:0] data;
        shifted = {cur[SIG_W-2:0], 1'b0};
        data    = {{(SIG_W-6){1'b0}}, op_v, ans_v};
        if (cur[SIG_W-1]) begin
            shifted = shifted ^ POLY;
        end else begin
            shifted = shifted;
        end
        return shifted ^ data;
    endfunction

    assign cnt_inc_s = cnt_q + CNT_ONE;

    // Next-state, signature, count and verdict; start beats sample_valid in every state.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        if (start) begin
            state_d = ST_RUN;
            sig_d   = SEED;
            cnt_d   = CNT_ZERO;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (sample_valid) begin
                        sig_d = misr_step(sig_q, op, ans);
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == CNT_LAST) begin
                            state_d = ST_CMP;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_CMP: begin
                    pass_d  = (sig_q == golden);
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; busy/done are decoded from the next state so they leave flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= CNT_ZERO;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_alu_resp_sig.sv
// Bench for alu_resp_sig: a default-parameter instance and a NUM_SAMPLES=2
// instance share stimulus; expectations come from constants and a MISR model.
module tb_alu_resp_sig;

    localparam int POLY_I = 32'h1021;
    localparam int SEED_I = 32'hFFFF;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sample_valid;
    logic [3:0]  ans;
    logic [1:0]  op;
    logic [15:0] golden1;
    logic [15:0] golden2;
    logic        busy1, done1, pass1;
    logic        busy2, done2, pass2;
    logic [15:0] sig1, sig2;
    logic [15:0] cnt1, cnt2;

    int total;
    int bad;

    alu_resp_sig u_dut (
        .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .ans(ans), .op(op), .golden(golden1),
        .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .count(cnt1)
    );

    alu_resp_sig #(.NUM_SAMPLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .ans(ans), .op(op), .golden(golden2),
        .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [3:0]  ans;
        logic [15:0] exp_sig;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[4];

    // Signature model from the polynomial-division rule, in plain integer arithmetic.
    function automatic int model_step(input int s, input int o, input int a);
        int t;
        t = (s * 2) % 65536;
        if (s >= 32768) t = t ^ POLY_I;
        return t ^ (o * 16 + a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int model_sig;
    int model_cnt;
    int acc;
    int guard;
    logic [1:0] run_op[300];
    logic [3:0] run_ans[300];

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        start = 1'b0;
        sample_valid = 1'b0;
        ans = 4'd0;
        op = 2'd0;
        golden1 = 16'h0000;
        golden2 = 16'hCFAF;

        vecs[0] = '{1'b1, 2'd1, 4'd8, 16'hEFC7, 16'd1};
        vecs[1] = '{1'b0, 2'd3, 4'd15, 16'hEFC7, 16'd1};
        vecs[2] = '{1'b0, 2'd2, 4'd5, 16'hEFC7, 16'd1};
        vecs[3] = '{1'b1, 2'd0, 4'd0, 16'hCFAF, 16'd2};

        // reset state
        tick(); tick();
        chk("rst_sig", int'(sig1), SEED_I);
        chk("rst_cnt", int'(cnt1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_pass", int'(pass1), 0);

        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_sig", int'(sig1), SEED_I);
        chk("start_busy", int'(busy1), 1);
        chk("start_cnt", int'(cnt1), 0);

        // table-driven first samples, idle gaps in between
        for (int i = 0; i < 4; i++) begin
            sample_valid = vecs[i].valid;
            op = vecs[i].op;
            ans = vecs[i].ans;
            tick();
            chk($sformatf("vec%0d_sig", i), int'(sig1), int'(vecs[i].exp_sig));
            chk($sformatf("vec%0d_cnt", i), int'(cnt1), int'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_busy", i), int'(busy1), 1);
        end
        sample_valid = 1'b0;

        // NUM_SAMPLES=2 instance: now in CMP, verdict one cycle later
        chk("n2_cmp_busy", int'(busy2), 0);
        chk("n2_cmp_done", int'(done2), 0);
        tick();
        chk("n2_done", int'(done2), 1);
        chk("n2_pass", int'(pass2), 1);
        chk("n2_busy", int'(busy2), 0);

        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            op = 2'(i);
            ans = 4'(i + 3);
            tick();
        end
        sample_valid = 1'b0;
        chk("n2_hold_sig", int'(sig2), 32'hCFAF);
        chk("n2_hold_cnt", int'(cnt2), 2);
        chk("n2_hold_pass", int'(pass2), 1);
        chk("n2_hold_done", int'(done2), 1);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("n2_restart_sig", int'(sig2), SEED_I);
        chk("n2_restart_cnt", int'(cnt2), 0);
        chk("n2_restart_done", int'(done2), 0);
        chk("n2_restart_busy", int'(busy2), 1);
        chk("n2_restart_pass", int'(pass2), 0);

        // wrong golden -> fail verdict
        golden2 = 16'h0000;
        sample_valid = 1'b1; op = 2'd1; ans = 4'd8; tick();
        op = 2'd0; ans = 4'd0; tick();
        sample_valid = 1'b0;
        tick();
        chk("n2_bad_done", int'(done2), 1);
        chk("n2_bad_pass", int'(pass2), 0);
        chk("n2_bad_sig", int'(sig2), 32'hCFAF);

        // mid-run reset on the default instance
        start = 1'b1; tick(); start = 1'b0;
        model_sig = SEED_I;
        for (int i = 0; i < 100; i++) begin
            sample_valid = 1'b1;
            op = 2'($urandom_range(0, 3));
            ans = 4'($urandom_range(0, 15));
            model_sig = model_step(model_sig, int'(op), int'(ans));
            tick();
        end
        chk("mid_cnt", int'(cnt1), 100);
        chk("mid_sig", int'(sig1), model_sig);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_sig", int'(sig1), SEED_I);
        chk("mrst_cnt", int'(cnt1), 0);
        chk("mrst_busy", int'(busy1), 0);
        for (int i = 0; i < 3; i++) tick();
        sample_valid = 1'b0;
        chk("idle_sig", int'(sig1), SEED_I);
        chk("idle_cnt", int'(cnt1), 0);

        // run a little, then start+sample together discards the sample
        start = 1'b1; tick(); start = 1'b0;
        sample_valid = 1'b1; op = 2'd2; ans = 4'd9; tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("ss_sig", int'(sig1), SEED_I);
        chk("ss_cnt", int'(cnt1), 0);
        chk("ss_busy", int'(busy1), 1);

        // full random run of 300 accepted samples with gaps
        model_sig = SEED_I;
        for (int i = 0; i < 300; i++) begin
            run_op[i] = 2'($urandom_range(0, 3));
            run_ans[i] = 4'($urandom_range(0, 15));
            model_sig = model_step(model_sig, int'(run_op[i]), int'(run_ans[i]));
        end
        golden1 = 16'(model_sig);
        acc = 0;
        guard = 0;
        model_cnt = 0;
        while (acc < 300 && guard < 3000) begin
            guard = guard + 1;
            if ($urandom_range(0, 3) != 0) begin
                sample_valid = 1'b1;
                op = run_op[acc];
                ans = run_ans[acc];
                acc = acc + 1;
            end else begin
                sample_valid = 1'b0;
                op = 2'($urandom_range(0, 3));
                ans = 4'($urandom_range(0, 15));
            end
            tick();
            if (acc == 299 && sample_valid) begin
                chk("run_299_busy", int'(busy1), 1);
                chk("run_299_cnt", int'(cnt1), 299);
            end
        end
        sample_valid = 1'b0;
        chk("run_guard", acc, 300);
        chk("run_cmp_done", int'(done1), 0);
        chk("run_cmp_busy", int'(busy1), 0);
        tick();
        chk("run_done", int'(done1), 1);
        chk("run_pass", int'(pass1), 1);
        chk("run_sig", int'(sig1), model_sig);
        chk("run_cnt", int'(cnt1), 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
